// File: rtl/vm_pkg.sv
// Shared widths and FSM encoding for the vending machine controller.
package vm_pkg;

   localparam int DEF_NUM_TYPES = 8;
   localparam int DEF_TYPE_W    = 3;
   localparam int DEF_PRICE_W   = 4;
   localparam int DEF_QTY_W     = 4;
   localparam int DEF_CREDIT_W  = 8;
   localparam int DEF_ACC_W     = 12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      DISPENSE = 2'd2
   } state_t;

endpackage

// File: rtl/vending_machine_ctrl_if.sv
// Customer purchase interface: the customer side is master, the machine is slave.
interface vending_machine_ctrl_if #(
   parameter int TYPE_W   = vm_pkg::DEF_TYPE_W,
   parameter int PRICE_W  = vm_pkg::DEF_PRICE_W,
   parameter int QTY_W    = vm_pkg::DEF_QTY_W,
   parameter int CREDIT_W = vm_pkg::DEF_CREDIT_W
);
   logic                coin_valid;
   logic [PRICE_W-1:0]  coin_val;
   logic                coin_reject;
   logic                req_valid;
   logic [TYPE_W-1:0]   req_type;
   logic [QTY_W-1:0]    req_amount;
   logic                cancel;
   logic                ready;
   logic [CREDIT_W-1:0] credit;
   logic                dispense_valid;
   logic [TYPE_W-1:0]   dispense_type;
   logic [QTY_W-1:0]    dispense_amount;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                red_light;

   modport master (
      output coin_valid, coin_val, req_valid, req_type, req_amount, cancel,
      input  coin_reject, ready, credit, dispense_valid, dispense_type,
             dispense_amount, change_valid, change_amt, red_light
   );

   modport slave (
      input  coin_valid, coin_val, req_valid, req_type, req_amount, cancel,
      output coin_reject, ready, credit, dispense_valid, dispense_type,
             dispense_amount, change_valid, change_amt, red_light
   );
endinterface

// File: rtl/vm_inventory.sv
// Per-slot price/supply register file: config writes, purchase decrements,
// combinational read of the slot selected by rd_type.
module vm_inventory
   import vm_pkg::*;
#(
   parameter int NUM_TYPES = DEF_NUM_TYPES,
   parameter int TYPE_W    = DEF_TYPE_W,
   parameter int PRICE_W   = DEF_PRICE_W,
   parameter int QTY_W     = DEF_QTY_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [TYPE_W-1:0]  cfg_type,
   input  logic [PRICE_W-1:0] cfg_price,
   input  logic [PRICE_W-1:0] cfg_supply,
   input  logic               dec_en,
   input  logic [TYPE_W-1:0]  dec_type,
   input  logic [QTY_W-1:0]   dec_amount,
   input  logic [TYPE_W-1:0]  rd_type,
   output logic [PRICE_W-1:0] rd_price,
   output logic [PRICE_W-1:0] rd_supply
);

   logic [PRICE_W-1:0] price_r  [NUM_TYPES];
   logic [PRICE_W-1:0] supply_r [NUM_TYPES];

   // Table update: config write wins; decrement only happens outside IDLE anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_TYPES; i++) begin
            price_r[i]  <= {PRICE_W{1'b0}};
            supply_r[i] <= {PRICE_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_TYPES; i++) begin
            if (cfg_we && (cfg_type == TYPE_W'(i))) begin
               price_r[i]  <= cfg_price;
               supply_r[i] <= cfg_supply;
            end else if (dec_en && (dec_type == TYPE_W'(i))) begin
               supply_r[i] <= supply_r[i] - PRICE_W'(dec_amount);
            end
         end
      end
   end

   assign rd_price  = price_r[rd_type];
   assign rd_supply = supply_r[rd_type];

endmodule

// File: rtl/vending_machine_ctrl.sv
// Machine-side purchase controller: credit handling, price/stock check,
// dispense and change generation, revenue accumulation.
module vending_machine_ctrl
   import vm_pkg::*;
#(
   parameter int NUM_TYPES = DEF_NUM_TYPES,
   parameter int TYPE_W    = DEF_TYPE_W,
   parameter int PRICE_W   = DEF_PRICE_W,
   parameter int QTY_W     = DEF_QTY_W,
   parameter int CREDIT_W  = DEF_CREDIT_W,
   parameter int ACC_W     = DEF_ACC_W
) (
   input  logic               clk,
   input  logic               rst,
   vending_machine_ctrl_if.slave cust,
   input  logic               cfg_we,
   input  logic [TYPE_W-1:0]  cfg_type,
   input  logic [PRICE_W-1:0] cfg_price,
   input  logic [PRICE_W-1:0] cfg_supply,
   output logic [ACC_W-1:0]   machine_acc
);

   localparam int PROD_W = PRICE_W + QTY_W;

   state_t              state_r, next_state_s;
   logic [CREDIT_W-1:0] credit_r, chg_amt_r;
   logic [ACC_W-1:0]    acc_r;
   logic                red_r, reject_r, disp_valid_r, chg_valid_r;
   logic [TYPE_W-1:0]   type_r, disp_type_r;
   logic [QTY_W-1:0]    amt_r, disp_amt_r;

   logic [PRICE_W-1:0]  price_s, supply_s;
   logic [CREDIT_W:0]   coin_sum_s;
   logic [PROD_W-1:0]   prod_s;
   logic [CREDIT_W-1:0] cost_s;
   logic                pass_s, cfg_en_s, dec_en_s, idle_s;

   assign idle_s     = (state_r == IDLE);
   assign coin_sum_s = {1'b0, credit_r} + (CREDIT_W+1)'(cust.coin_val);
   assign prod_s     = PROD_W'(price_s) * PROD_W'(amt_r);
   assign cost_s     = CREDIT_W'(prod_s);
   assign pass_s     = (amt_r != {QTY_W{1'b0}}) &&
                       (PROD_W'(amt_r) <= PROD_W'(supply_s)) &&
                       (credit_r >= cost_s);
   // A request in the same cycle owns the slot, so config writes are dropped then.
   assign cfg_en_s   = idle_s && cfg_we && !cust.req_valid;
   assign dec_en_s   = (state_r == CHECK) && pass_s;

   vm_inventory #(
      .NUM_TYPES (NUM_TYPES),
      .TYPE_W    (TYPE_W),
      .PRICE_W   (PRICE_W),
      .QTY_W     (QTY_W)
   ) u_inventory (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_en_s),
      .cfg_type   (cfg_type),
      .cfg_price  (cfg_price),
      .cfg_supply (cfg_supply),
      .dec_en     (dec_en_s),
      .dec_type   (type_r),
      .dec_amount (amt_r),
      .rd_type    (type_r),
      .rd_price   (price_s),
      .rd_supply  (supply_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= next_state_s;
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cust.req_valid && !cust.cancel) next_state_s = CHECK;
            else                                next_state_s = IDLE;
         end
         CHECK: begin
            if (pass_s) next_state_s = DISPENSE;
            else        next_state_s = IDLE;
         end
         DISPENSE: next_state_s = IDLE;
         default:  next_state_s = IDLE;
      endcase
   end

   // Credit, revenue, indicator and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_r     <= {CREDIT_W{1'b0}};
         acc_r        <= {ACC_W{1'b0}};
         red_r        <= 1'b0;
         reject_r     <= 1'b0;
         disp_valid_r <= 1'b0;
         disp_type_r  <= {TYPE_W{1'b0}};
         disp_amt_r   <= {QTY_W{1'b0}};
         chg_valid_r  <= 1'b0;
         chg_amt_r    <= {CREDIT_W{1'b0}};
         type_r       <= {TYPE_W{1'b0}};
         amt_r        <= {QTY_W{1'b0}};
      end else begin
         reject_r     <= 1'b0;
         disp_valid_r <= 1'b0;
         chg_valid_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cust.cancel) begin
                  chg_valid_r <= (credit_r != {CREDIT_W{1'b0}});
                  chg_amt_r   <= credit_r;
                  credit_r    <= {CREDIT_W{1'b0}};
                  red_r       <= 1'b0;
                  reject_r    <= cust.coin_valid;
               end else begin
                  if (cust.coin_valid) begin
                     if (!coin_sum_s[CREDIT_W]) credit_r <= coin_sum_s[CREDIT_W-1:0];
                     else                       reject_r <= 1'b1;
                  end
                  if (cust.req_valid) begin
                     type_r <= cust.req_type;
                     amt_r  <= cust.req_amount;
                  end
               end
            end
            CHECK: begin
               reject_r <= cust.coin_valid;
               // Pulses are set here so they are registered high during DISPENSE.
               if (pass_s) begin
                  acc_r        <= acc_r + ACC_W'(prod_s);
                  credit_r     <= {CREDIT_W{1'b0}};
                  red_r        <= 1'b0;
                  disp_valid_r <= 1'b1;
                  disp_type_r  <= type_r;
                  disp_amt_r   <= amt_r;
                  chg_valid_r  <= (credit_r != cost_s);
                  chg_amt_r    <= credit_r - cost_s;
               end else begin
                  red_r <= 1'b1;
               end
            end
            DISPENSE: reject_r <= cust.coin_valid;
            default:  reject_r <= 1'b0;
         endcase
      end
   end

   assign cust.ready           = idle_s;
   assign cust.credit          = credit_r;
   assign cust.coin_reject     = reject_r;
   assign cust.dispense_valid  = disp_valid_r;
   assign cust.dispense_type   = disp_type_r;
   assign cust.dispense_amount = disp_amt_r;
   assign cust.change_valid    = chg_valid_r;
   assign cust.change_amt      = chg_amt_r;
   assign cust.red_light       = red_r;
   assign machine_acc          = acc_r;

endmodule
